// File: rtl/wisc_pkg.sv
// Shared WISC-15 definitions: opcode map, instruction width and the
// fetch-stage state encoding used by the fetch unit.
package wisc_pkg;

  localparam int INST_W = 16;

  // Opcode map, instruction bits [15:12]; shared with the control unit.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_LI   = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    FS_BOOT  = 3'd0,
    FS_ISSUE = 3'd1,
    FS_WAIT  = 3'd2,
    FS_HOLD  = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_e;

  // True when the opcode field denotes a halt instruction.
  function automatic logic is_halt(input logic [3:0] opcode);
    return (opcode == OP_HLT);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// WISC-15 instruction fetch stage. Keeps the PC, issues one read at a time
// to instruction memory, hands each word to decode with valid/ready, follows
// redirects from execute and parks after a halt instruction is accepted.
// Every output is a register or a pure decode of the state register.
module fetch_unit
  import wisc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  // State and datapath registers; reset parks fetch in BOOT at RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FS_BOOT;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= {INST_W{1'b0}};
      inst_pc_q <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next-state logic: a redirect always wins over accepting the held word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_BOOT: begin
        state_d = FS_ISSUE;
      end
      FS_ISSUE: begin
        state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_valid) begin
          // A stale response (pending drop or same-cycle redirect) refetches.
          if (drop_q || redir_valid) begin
            state_d = FS_ISSUE;
          end else begin
            state_d = FS_HOLD;
          end
        end else begin
          state_d = FS_WAIT;
        end
      end
      FS_HOLD: begin
        if (redir_valid) begin
          state_d = FS_ISSUE;
        end else if (inst_ready) begin
          if (is_halt(inst_q[15:12])) begin
            state_d = FS_HALT;
          end else begin
            state_d = FS_ISSUE;
          end
        end else begin
          state_d = FS_HOLD;
        end
      end
      FS_HALT: begin
        if (redir_valid) begin
          state_d = FS_ISSUE;
        end else begin
          state_d = FS_HALT;
        end
      end
      default: begin
        state_d = FS_BOOT;
      end
    endcase
  end

  // Datapath updates: PC steering, stale-read tracking and instruction capture.
  always_comb begin
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      FS_ISSUE: begin
        // The read just issued targets the old PC, so its response is stale.
        if (redir_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      FS_WAIT: begin
        if (redir_valid) begin
          pc_d   = redir_pc;
          // A response arriving this same cycle is discarded right now;
          // otherwise remember to discard the one still in flight.
          drop_d = ~imem_valid;
        end else if (imem_valid) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
          end
        end else begin
          drop_d = drop_q;
        end
      end
      FS_HOLD: begin
        if (redir_valid) begin
          pc_d = redir_pc;
        end else if (inst_ready) begin
          pc_d = pc_q + PC_ONE;
        end else begin
          pc_d = pc_q;
        end
      end
      FS_HALT: begin
        if (redir_valid) begin
          pc_d = redir_pc;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Output decode from state and registers only; no input reaches an output.
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    halted     = 1'b0;
    imem_addr  = pc_q;
    inst_out   = inst_q;
    inst_pc    = inst_pc_q;
    case (state_q)
      FS_ISSUE: begin
        imem_req = 1'b1;
      end
      FS_HOLD: begin
        inst_valid = 1'b1;
      end
      FS_HALT: begin
        halted = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle table from reset, hand-written
// stall / redirect / halt / reset sequences, and a randomized run checked
// against a program-order model (next expected PC plus memory contents).
module tb_fetch_unit;
  import wisc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: RESET_PC = 0
  logic        rst0 = 1'b1, imem_req0, imem_valid0 = 1'b0, inst_valid0;
  logic        inst_ready0 = 1'b0, redir_valid0 = 1'b0, halted0;
  logic [15:0] imem_addr0, imem_rdata0 = 16'h0, inst_out0, inst_pc0, redir_pc0 = 16'h0;
  // Instance 1: RESET_PC = 0xFFFF
  logic        rst1 = 1'b1, imem_req1, imem_valid1 = 1'b0, inst_valid1;
  logic        inst_ready1 = 1'b0, redir_valid1 = 1'b0, halted1;
  logic [15:0] imem_addr1, imem_rdata1 = 16'h0, inst_out1, inst_pc1, redir_pc1 = 16'h0;

  int tests = 0;
  int fails = 0;
  logic [15:0] mem [65536];

  fetch_unit dut0 (
    .clk(clk), .rst(rst0), .imem_req(imem_req0), .imem_addr(imem_addr0),
    .imem_rdata(imem_rdata0), .imem_valid(imem_valid0), .inst_out(inst_out0),
    .inst_pc(inst_pc0), .inst_valid(inst_valid0), .inst_ready(inst_ready0),
    .redir_valid(redir_valid0), .redir_pc(redir_pc0), .halted(halted0)
  );

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst1), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_rdata(imem_rdata1), .imem_valid(imem_valid1), .inst_out(inst_out1),
    .inst_pc(inst_pc1), .inst_valid(inst_valid1), .inst_ready(inst_ready1),
    .redir_valid(redir_valid1), .redir_pc(redir_pc1), .halted(halted1)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: hashed words, never a HLT opcode unless placed on purpose.
  function automatic logic [15:0] hash_word(input int a);
    logic [31:0] h;
    h = 32'(a) * 32'd40503 + 32'd12345;
    if (h[15:12] == 4'hF) h[15:12] = 4'h7;
    return h[15:0];
  endfunction

  // Memory model 0: fixed or random latency, one response per request.
  int          lat0 = 1;
  bit          rand_lat0 = 1'b0;
  int          cnt0 = 0;
  logic [15:0] maddr0 = 16'h0;
  always @(negedge clk) begin
    if (cnt0 > 0) begin
      cnt0--;
      imem_valid0 = (cnt0 == 0);
      if (cnt0 == 0) imem_rdata0 = mem[maddr0];
    end else begin
      imem_valid0 = 1'b0;
    end
    if (imem_req0) begin
      tests++;
      if (cnt0 != 0) begin
        fails++;
        $display("FAIL one_outstanding0: request at %h while %0d cycles pending", imem_addr0, cnt0);
      end
      cnt0   = rand_lat0 ? int'($urandom_range(1, 3)) : lat0;
      maddr0 = imem_addr0;
    end
  end

  // Memory model 1: fixed 2-cycle latency.
  int          cnt1 = 0;
  logic [15:0] maddr1 = 16'h0;
  always @(negedge clk) begin
    if (cnt1 > 0) begin
      cnt1--;
      imem_valid1 = (cnt1 == 0);
      if (cnt1 == 0) imem_rdata1 = mem[maddr1];
    end else begin
      imem_valid1 = 1'b0;
    end
    if (imem_req1) begin
      tests++;
      if (cnt1 != 0) begin
        fails++;
        $display("FAIL one_outstanding1: request at %h while %0d cycles pending", imem_addr1, cnt1);
      end
      cnt1   = 2;
      maddr1 = imem_addr1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid0(input string tag);
    int n = 0;
    while (!inst_valid0 && n < 30) begin
      step();
      n++;
    end
    chk1(tag, inst_valid0, 1'b1);
  endtask

  task automatic wait_valid1(input string tag);
    int n = 0;
    while (!inst_valid1 && n < 30) begin
      step();
      n++;
    end
    chk1(tag, inst_valid1, 1'b1);
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        iv;
    logic [15:0] inst;
    logic [15:0] ipc;
    logic        hlt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] s_inst, s_pc, exp_next, rtgt;
    logic        rv, rdy, prev_hold;
    int          n, accepts;

    for (int a = 0; a < 65536; a++) mem[a] = hash_word(a);
    mem[16'h0000] = 16'h0123;
    mem[16'h0001] = 16'h2456;
    mem[16'h0005] = 16'hF000;
    mem[16'h0040] = 16'h3ABC;

    //            rdy   rv    rpc       req   addr      iv    inst      ipc       hlt
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}; // BOOT
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}; // ISSUE 0
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}; // WAIT
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0123, 16'h0000, 1'b0}; // HOLD
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0123, 16'h0000, 1'b0}; // ISSUE 1
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'h0123, 16'h0000, 1'b0}; // WAIT
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 16'h2456, 16'h0001, 1'b0}; // HOLD
    tbl[7]  = '{1'b1, 1'b1, 16'h0040, 1'b1, 16'h0002, 1'b0, 16'h2456, 16'h0001, 1'b0}; // ISSUE 2 + redirect
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h2456, 16'h0001, 1'b0}; // WAIT, stale dropped
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h2456, 16'h0001, 1'b0}; // ISSUE 40
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h2456, 16'h0001, 1'b0}; // WAIT
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b1, 16'h3ABC, 16'h0040, 1'b0}; // HOLD, stall
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b1, 16'h3ABC, 16'h0040, 1'b0}; // HOLD, accept
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b0, 16'h3ABC, 16'h0040, 1'b0}; // ISSUE 41

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req", imem_req0, 1'b0);
    chk16("rst_addr", imem_addr0, 16'h0000);
    chk1("rst_iv", inst_valid0, 1'b0);
    chk16("rst_inst", inst_out0, 16'h0000);
    chk16("rst_ipc", inst_pc0, 16'h0000);
    chk1("rst_halted", halted0, 1'b0);
    chk16("rst1_addr", imem_addr1, 16'hFFFF);
    chk1("rst1_req", imem_req1, 1'b0);
    rst0 = 1'b0;

    // ---- cycle table from reset, 1-cycle memory ----
    for (int i = 0; i < 14; i++) begin
      chk1($sformatf("tbl%0d_req", i), imem_req0, tbl[i].req);
      chk16($sformatf("tbl%0d_addr", i), imem_addr0, tbl[i].addr);
      chk1($sformatf("tbl%0d_iv", i), inst_valid0, tbl[i].iv);
      chk16($sformatf("tbl%0d_inst", i), inst_out0, tbl[i].inst);
      chk16($sformatf("tbl%0d_ipc", i), inst_pc0, tbl[i].ipc);
      chk1($sformatf("tbl%0d_halted", i), halted0, tbl[i].hlt);
      inst_ready0  = tbl[i].rdy;
      redir_valid0 = tbl[i].rv;
      redir_pc0    = tbl[i].rpc;
      step();
    end
    redir_valid0 = 1'b0;

    // ---- decode stall for 5 cycles ----
    inst_ready0 = 1'b0;
    wait_valid0("stall_wait");
    chk16("stall_pc", inst_pc0, 16'h0041);
    chk16("stall_inst", inst_out0, mem[16'h0041]);
    s_inst = inst_out0;
    s_pc   = inst_pc0;
    for (int i = 0; i < 5; i++) begin
      chk1("stall_iv", inst_valid0, 1'b1);
      chk1("stall_noreq", imem_req0, 1'b0);
      chk16("stall_inst_stable", inst_out0, s_inst);
      chk16("stall_pc_stable", inst_pc0, s_pc);
      step();
    end
    inst_ready0 = 1'b1;
    step();
    inst_ready0 = 1'b0;
    chk1("after_accept_req", imem_req0, 1'b1);
    chk16("after_accept_addr", imem_addr0, s_pc + 16'd1);

    // ---- redirect in WAIT with 4-cycle memory ----
    lat0 = 4;
    step();
    redir_valid0 = 1'b1;
    redir_pc0    = 16'h0040;
    step();
    redir_valid0 = 1'b0;
    n = 1;
    while (!imem_req0 && n < 20) begin
      chk1("wredir_no_iv", inst_valid0, 1'b0);
      step();
      n++;
    end
    chk16("wredir_req_delay", 16'(n), 16'd4);
    chk16("wredir_addr", imem_addr0, 16'h0040);
    wait_valid0("wredir_wait");
    chk16("wredir_ipc", inst_pc0, 16'h0040);
    chk16("wredir_inst", inst_out0, 16'h3ABC);
    lat0 = 1;

    // ---- halt at pc 5, then redirect out ----
    redir_valid0 = 1'b1;
    redir_pc0    = 16'h0005;
    step();
    redir_valid0 = 1'b0;
    wait_valid0("hlt_wait");
    chk16("hlt_ipc", inst_pc0, 16'h0005);
    chk16("hlt_inst", inst_out0, 16'hF000);
    inst_ready0 = 1'b1;
    step();
    inst_ready0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk1("halt_halted", halted0, 1'b1);
      chk1("halt_noreq", imem_req0, 1'b0);
      step();
    end
    redir_valid0 = 1'b1;
    redir_pc0    = 16'h0010;
    step();
    redir_valid0 = 1'b0;
    chk1("unhalt_halted", halted0, 1'b0);
    chk1("unhalt_req", imem_req0, 1'b1);
    chk16("unhalt_addr", imem_addr0, 16'h0010);

    // ---- HLT accept with simultaneous redirect ----
    wait_valid0("hltrd_wait0");
    redir_valid0 = 1'b1;
    redir_pc0    = 16'h0005;
    step();
    redir_valid0 = 1'b0;
    wait_valid0("hltrd_wait1");
    chk16("hltrd_ipc", inst_pc0, 16'h0005);
    inst_ready0  = 1'b1;
    redir_valid0 = 1'b1;
    redir_pc0    = 16'h0020;
    step();
    inst_ready0  = 1'b0;
    redir_valid0 = 1'b0;
    chk1("hltrd_halted", halted0, 1'b0);
    chk1("hltrd_req", imem_req0, 1'b1);
    chk16("hltrd_addr", imem_addr0, 16'h0020);

    // ---- randomized run against the program-order model ----
    rand_lat0 = 1'b1;
    exp_next  = 16'h0000;
    prev_hold = 1'b0;
    s_inst    = 16'h0000;
    s_pc      = 16'h0000;
    accepts   = 0;
    for (int c = 0; c < 2000; c++) begin
      if (prev_hold) begin
        chk1("rnd_hold_iv", inst_valid0, 1'b1);
        chk16("rnd_hold_inst", inst_out0, s_inst);
        chk16("rnd_hold_pc", inst_pc0, s_pc);
      end
      rv   = (c == 0) || ($urandom_range(0, 19) == 0);
      rtgt = (c == 0) ? 16'h0100 : 16'(16'h0100 + $urandom_range(0, 255));
      rdy  = 1'($urandom_range(0, 1));
      if (inst_valid0 && rdy && !rv) begin
        chk16("rnd_ipc", inst_pc0, exp_next);
        chk16("rnd_inst", inst_out0, mem[exp_next]);
        exp_next = exp_next + 16'd1;
        accepts++;
      end
      if (rv) exp_next = rtgt;
      prev_hold    = inst_valid0 && !rdy && !rv;
      s_inst       = inst_out0;
      s_pc         = inst_pc0;
      inst_ready0  = rdy;
      redir_valid0 = rv;
      redir_pc0    = rtgt;
      step();
    end
    redir_valid0 = 1'b0;
    inst_ready0  = 1'b0;
    chk1("rnd_progress", (accepts >= 100), 1'b1);

    // ---- RESET_PC = 0xFFFF: wrap and reset mid-read ----
    rst1 = 1'b0;
    chk1("w_boot_req", imem_req1, 1'b0);
    chk16("w_boot_addr", imem_addr1, 16'hFFFF);
    step();
    chk1("w_issue_req", imem_req1, 1'b1);
    chk16("w_issue_addr", imem_addr1, 16'hFFFF);
    wait_valid1("w_wait");
    chk16("w_ipc", inst_pc1, 16'hFFFF);
    chk16("w_inst", inst_out1, mem[16'hFFFF]);
    inst_ready1 = 1'b1;
    step();
    inst_ready1 = 1'b0;
    chk1("wrap_req", imem_req1, 1'b1);
    chk16("wrap_addr", imem_addr1, 16'h0000);
    step();
    rst1 = 1'b1;
    #1;
    chk1("mrst_req", imem_req1, 1'b0);
    chk1("mrst_iv", inst_valid1, 1'b0);
    chk1("mrst_halted", halted1, 1'b0);
    chk16("mrst_inst", inst_out1, 16'h0000);
    chk16("mrst_ipc", inst_pc1, 16'h0000);
    chk16("mrst_addr", imem_addr1, 16'hFFFF);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    chk1("mrst_boot_req", imem_req1, 1'b0);
    step();
    chk1("mrst_issue_req", imem_req1, 1'b1);
    chk16("mrst_issue_addr", imem_addr1, 16'hFFFF);
    wait_valid1("mrst_wait");
    chk16("mrst_first_ipc", inst_pc1, 16'hFFFF);
    chk16("mrst_first_inst", inst_out1, mem[16'hFFFF]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
